node_line_decoder: RTL and testbench

- Upstream stage of node_id_mapper for the 2025 day 11 device graph.
- Parses the puzzle's ASCII byte stream, one line per node in the form "abc: def ghi\n", into packed 15-bit node strings.
- Emits one src pulse per line and one edge pulse per destination token.
- Signals end of decoding once the final token has been flushed.

---
 rtl/node_str_pkg.sv | 41 ++++
 rtl/node_line_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_node_line_decoder.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/node_str_pkg.sv
// Shared definitions for the day 11 node-string front end: char encoding,
// byte constants of the line grammar, decoder FSM states and helpers.
package node_str_pkg;

    localparam int NODE_STR_WIDTH = 15;
    localparam int CHAR_WIDTH     = 5;

    localparam logic [7:0] A_CHAR = 8'h61;
    localparam logic [7:0] COLON  = 8'h3A;
    localparam logic [7:0] SPACE  = 8'h20;
    localparam logic [7:0] LF     = 8'h0A;
    localparam logic [7:0] CR     = 8'h0D;

    typedef logic [NODE_STR_WIDTH-1:0] node_str_t;

    typedef enum logic [2:0] {
        SRC_TOKEN,
        EXPECT_SPACE,
        DST_TOKEN,
        ERROR_SKIP,
        DONE
    } dec_state_e;

    function automatic logic is_lower(input logic [7:0] b);
        return (b >= 8'h61) && (b <= 8'h7A);
    endfunction

    function automatic logic [CHAR_WIDTH-1:0] char_code(input logic [7:0] b);
        logic [7:0] d;
        d = b - A_CHAR;
        return d[CHAR_WIDTH-1:0];
    endfunction

    // Packs three ASCII chars; char 0 lands in the least significant slot.
    function automatic node_str_t node_str_from_ascii(input logic [7:0] c0,
                                                      input logic [7:0] c1,
                                                      input logic [7:0] c2);
        return {char_code(c2), char_code(c1), char_code(c0)};
    endfunction

endpackage

// File: rtl/node_line_decoder.sv
// Byte-stream parser for "abc: def ghi\n" lines. Emits a src pulse per line,
// an edge pulse per destination token, and a sticky done flag at the end.
module node_line_decoder
    import node_str_pkg::*;
#(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                inbound_byte,
    input  logic                      inbound_valid,
    input  logic                      end_of_input,
    output logic                      src_node_str_valid,
    output logic                      edge_str_valid,
    output logic [NODE_STR_WIDTH-1:0] src_node_str,
    output logic [NODE_STR_WIDTH-1:0] dst_node_str,
    output logic                      decoding_done_str,
    output logic                      parse_error,
    output logic [COUNT_WIDTH-1:0]    line_count,
    output logic [COUNT_WIDTH-1:0]    edge_count
);

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    dec_state_e               state_q, state_d;
    logic [1:0]               pos_q, pos_d;
    node_str_t                tok_q, tok_d;
    logic                     pend_q, pend_d;
    logic                     srcValid_q, srcValid_d;
    logic                     edgeValid_q, edgeValid_d;
    node_str_t                src_q, src_d;
    node_str_t                dst_q, dst_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic [COUNT_WIDTH-1:0]   lineCnt_q, lineCnt_d;
    logic [COUNT_WIDTH-1:0]   edgeCnt_q, edgeCnt_d;

    logic endNow;
    logic byteNow;

    function automatic node_str_t place_char(input node_str_t s,
                                             input logic [1:0] p,
                                             input logic [CHAR_WIDTH-1:0] c);
        node_str_t r;
        r = s;
        case (p)
            2'd0:    r[0*CHAR_WIDTH +: CHAR_WIDTH] = c;
            2'd1:    r[1*CHAR_WIDTH +: CHAR_WIDTH] = c;
            default: r[2*CHAR_WIDTH +: CHAR_WIDTH] = c;
        endcase
        return r;
    endfunction

    // Next-state logic: end handling takes priority, then one byte per cycle.
    // A byte arriving with end_of_input is consumed first; the end is deferred
    // through pend_q. An LF that makes a line malformed also terminates it, so
    // the following line is never swallowed by the error skip.
    always_comb begin
        state_d     = state_q;
        pos_d       = pos_q;
        tok_d       = tok_q;
        pend_d      = pend_q;
        srcValid_d  = 1'b0;
        edgeValid_d = 1'b0;
        src_d       = src_q;
        dst_d       = dst_q;
        done_d      = done_q;
        err_d       = err_q;
        lineCnt_d   = lineCnt_q;
        edgeCnt_d   = edgeCnt_q;

        endNow  = pend_q || (end_of_input && !inbound_valid);
        byteNow = inbound_valid && !pend_q;

        if (state_q == DONE) begin
            done_d = 1'b1;
            pend_d = 1'b0;
        end else if (endNow) begin
            pend_d  = 1'b0;
            state_d = DONE;
            if (state_q == DST_TOKEN && pos_q == 2'd3) begin
                edgeValid_d = 1'b1;
                dst_d       = tok_q;
                edgeCnt_d   = edgeCnt_q + CNT_ONE;
                lineCnt_d   = lineCnt_q + CNT_ONE;
            end else begin
                done_d = 1'b1;
                if (!(state_q == SRC_TOKEN && pos_q == 2'd0)) begin
                    err_d = 1'b1;
                end
            end
        end else if (byteNow) begin
            if (end_of_input) begin
                pend_d = 1'b1;
            end
            if (inbound_byte != CR) begin
                case (state_q)
                    SRC_TOKEN: begin
                        if (is_lower(inbound_byte) && pos_q != 2'd3) begin
                            tok_d = place_char(tok_q, pos_q, char_code(inbound_byte));
                            pos_d = pos_q + 2'd1;
                        end else if (inbound_byte == COLON && pos_q == 2'd3) begin
                            srcValid_d = 1'b1;
                            src_d      = tok_q;
                            pos_d      = 2'd0;
                            state_d    = EXPECT_SPACE;
                        end else if (inbound_byte == LF && pos_q == 2'd0) begin
                            state_d = SRC_TOKEN;
                        end else if (inbound_byte == LF) begin
                            err_d   = 1'b1;
                            pos_d   = 2'd0;
                            state_d = SRC_TOKEN;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ERROR_SKIP;
                        end
                    end
                    EXPECT_SPACE: begin
                        pos_d = 2'd0;
                        if (inbound_byte == SPACE) begin
                            state_d = DST_TOKEN;
                        end else if (inbound_byte == LF) begin
                            err_d   = 1'b1;
                            state_d = SRC_TOKEN;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ERROR_SKIP;
                        end
                    end
                    DST_TOKEN: begin
                        if (is_lower(inbound_byte) && pos_q != 2'd3) begin
                            tok_d = place_char(tok_q, pos_q, char_code(inbound_byte));
                            pos_d = pos_q + 2'd1;
                        end else if (inbound_byte == SPACE && pos_q == 2'd3) begin
                            edgeValid_d = 1'b1;
                            dst_d       = tok_q;
                            edgeCnt_d   = edgeCnt_q + CNT_ONE;
                            pos_d       = 2'd0;
                        end else if (inbound_byte == LF && pos_q == 2'd3) begin
                            edgeValid_d = 1'b1;
                            dst_d       = tok_q;
                            edgeCnt_d   = edgeCnt_q + CNT_ONE;
                            lineCnt_d   = lineCnt_q + CNT_ONE;
                            pos_d       = 2'd0;
                            state_d     = SRC_TOKEN;
                        end else if (inbound_byte == LF) begin
                            err_d   = 1'b1;
                            pos_d   = 2'd0;
                            state_d = SRC_TOKEN;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ERROR_SKIP;
                        end
                    end
                    ERROR_SKIP: begin
                        err_d = 1'b1;
                        if (inbound_byte == LF) begin
                            pos_d   = 2'd0;
                            state_d = SRC_TOKEN;
                        end
                    end
                    default: begin
                        pos_d   = 2'd0;
                        state_d = SRC_TOKEN;
                    end
                endcase
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SRC_TOKEN;
            pos_q       <= 2'd0;
            tok_q       <= '0;
            pend_q      <= 1'b0;
            srcValid_q  <= 1'b0;
            edgeValid_q <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            lineCnt_q   <= '0;
            edgeCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            tok_q       <= tok_d;
            pend_q      <= pend_d;
            srcValid_q  <= srcValid_d;
            edgeValid_q <= edgeValid_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            done_q      <= done_d;
            err_q       <= err_d;
            lineCnt_q   <= lineCnt_d;
            edgeCnt_q   <= edgeCnt_d;
        end
    end

    assign src_node_str_valid = srcValid_q;
    assign edge_str_valid     = edgeValid_q;
    assign src_node_str       = src_q;
    assign dst_node_str       = dst_q;
    assign decoding_done_str  = done_q;
    assign parse_error        = err_q;
    assign line_count         = lineCnt_q;
    assign edge_count         = edgeCnt_q;

endmodule

// File: tb/tb_node_line_decoder.sv
// Scoreboard bench for node_line_decoder: a line-level reference model
// predicts every pulse, and a monitor pops and compares as pulses appear.
module tb_node_line_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  inbound_byte;
    logic        inbound_valid;
    logic        end_of_input;
    logic        src_node_str_valid;
    logic        edge_str_valid;
    logic [14:0] src_node_str;
    logic [14:0] dst_node_str;
    logic        decoding_done_str;
    logic        parse_error;
    logic [15:0] line_count;
    logic [15:0] edge_count;

    node_line_decoder #(.COUNT_WIDTH(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .inbound_byte       (inbound_byte),
        .inbound_valid      (inbound_valid),
        .end_of_input       (end_of_input),
        .src_node_str_valid (src_node_str_valid),
        .edge_str_valid     (edge_str_valid),
        .src_node_str       (src_node_str),
        .dst_node_str       (dst_node_str),
        .decoding_done_str  (decoding_done_str),
        .parse_error        (parse_error),
        .line_count         (line_count),
        .edge_count         (edge_count)
    );

    always #5 clk = ~clk;

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    typedef struct {
        logic [7:0] b;
        bit         hasByte;
        bit         eoi;
    } item_t;

    typedef struct {
        bit          isEdge;
        logic [14:0] str;
        int          lines;
        int          edges;
        int          refIdx;
        int          extra;
    } exp_t;

    item_t       itemQ[$];
    exp_t        expQ[$];
    int          issueCyc[$];
    logic [7:0]  lineC[$];
    int          lineI[$];

    int          checkTotal = 0;
    int          checkPass  = 0;
    int          doneRiseCyc = -1;
    bit          randGaps = 1'b0;

    int          mLines, mEdges, mEndIdx;
    bit          mErr, mSim, mFlush;
    logic [14:0] mSrc, mDst;
    exp_t        monE;

    task automatic check(input string name, input longint actual, input longint expected);
        checkTotal++;
        if (actual == expected) checkPass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    function automatic bit isLow(input logic [7:0] c);
        return (c >= 8'h61) && (c <= 8'h7A);
    endfunction

    function automatic logic [14:0] encode3(input logic [7:0] c0, input logic [7:0] c1,
                                            input logic [7:0] c2);
        int v;
        v = (int'(c0) - 97) + 32 * (int'(c1) - 97) + 1024 * (int'(c2) - 97);
        return v[14:0];
    endfunction

    function automatic void pushExp(input bit isEdge, input logic [14:0] s,
                                    input int refIdx, input int extra);
        exp_t e;
        e.isEdge = isEdge;
        e.str    = s;
        e.lines  = mLines;
        e.edges  = mEdges;
        e.refIdx = refIdx;
        e.extra  = extra;
        expQ.push_back(e);
    endfunction

    // Judges one whole line (CRs removed) by the grammar; edges for complete
    // tokens before the first defect still count.
    function automatic void modelLine(input bit lf, input int termIdx);
        int n;
        int p;
        n = lineC.size();
        if (n == 0) return;
        if (!(n >= 4 && isLow(lineC[0]) && isLow(lineC[1]) && isLow(lineC[2]) && lineC[3] == 8'h3A)) begin
            mErr = 1'b1;
            return;
        end
        mSrc = encode3(lineC[0], lineC[1], lineC[2]);
        pushExp(1'b0, mSrc, lineI[3], 0);
        if (n < 5 || lineC[4] != 8'h20) begin
            mErr = 1'b1;
            return;
        end
        p = 5;
        forever begin
            if (p + 3 > n || !(isLow(lineC[p]) && isLow(lineC[p+1]) && isLow(lineC[p+2]))) begin
                mErr = 1'b1;
                return;
            end
            if (p + 3 < n) begin
                if (lineC[p+3] != 8'h20) begin
                    mErr = 1'b1;
                    return;
                end
                mDst = encode3(lineC[p], lineC[p+1], lineC[p+2]);
                mEdges++;
                pushExp(1'b1, mDst, lineI[p+3], 0);
                p += 4;
            end else begin
                if (lf || mEndIdx >= 0) begin
                    mDst = encode3(lineC[p], lineC[p+1], lineC[p+2]);
                    mEdges++;
                    mLines++;
                    if (lf) pushExp(1'b1, mDst, termIdx, 0);
                    else begin
                        pushExp(1'b1, mDst, mEndIdx, int'(mSim));
                        mFlush = 1'b1;
                    end
                end
                return;
            end
        end
    endfunction

    function automatic void runModel();
        mLines = 0; mEdges = 0; mErr = 1'b0; mSim = 1'b0; mFlush = 1'b0;
        mSrc = '0; mDst = '0; mEndIdx = -1;
        lineC.delete(); lineI.delete();
        for (int i = 0; i < itemQ.size(); i++) begin
            if (itemQ[i].hasByte && itemQ[i].b != 8'h0D) begin
                if (itemQ[i].b == 8'h0A) begin
                    modelLine(1'b1, i);
                    lineC.delete(); lineI.delete();
                end else begin
                    lineC.push_back(itemQ[i].b);
                    lineI.push_back(i);
                end
            end
            if (itemQ[i].eoi) begin
                mEndIdx = i;
                mSim    = itemQ[i].hasByte;
                break;
            end
        end
        if (lineC.size() > 0) modelLine(1'b0, -1);
    endfunction

    task automatic addByte(input logic [7:0] b, input bit eoi);
        item_t it;
        it.b = b; it.hasByte = 1'b1; it.eoi = eoi;
        itemQ.push_back(it);
    endtask

    task automatic addText(input string s);
        for (int i = 0; i < s.len(); i++) addByte(s[i], 1'b0);
    endtask

    task automatic addEnd();
        item_t it;
        it.b = 8'h00; it.hasByte = 1'b0; it.eoi = 1'b1;
        itemQ.push_back(it);
    endtask

    task automatic addRandomText();
        logic [7:0] bq[$];
        logic [7:0] bad[8] = '{8'h41, 8'h31, 8'h3A, 8'h20, 8'h0A, 8'h0D, 8'h7B, 8'h60};
        int nLines;
        int nTok;
        nLines = $urandom_range(1, 5);
        for (int l = 0; l < nLines; l++) begin
            if ($urandom_range(0, 9) != 0) begin
                for (int k = 0; k < 3; k++) bq.push_back(8'h61 + 8'($urandom_range(0, 25)));
                bq.push_back(8'h3A);
                nTok = $urandom_range(1, 3);
                for (int t = 0; t < nTok; t++) begin
                    bq.push_back(8'h20);
                    for (int k = 0; k < 3; k++) bq.push_back(8'h61 + 8'($urandom_range(0, 25)));
                end
                if ($urandom_range(0, 5) == 0) bq[$urandom_range(0, bq.size() - 1)] = bad[$urandom_range(0, 7)];
            end
            if ($urandom_range(0, 3) == 0) bq.push_back(8'h0D);
            if (l != nLines - 1 || $urandom_range(0, 2) != 0) bq.push_back(8'h0A);
        end
        for (int i = 0; i < bq.size(); i++) begin
            addByte(bq[i], (i == bq.size() - 1) && $urandom_range(0, 2) == 0);
        end
        if (!itemQ[itemQ.size() - 1].eoi) addEnd();
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1; inbound_valid = 1'b0; end_of_input = 1'b0; inbound_byte = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_src_valid", src_node_str_valid, 0);
        check("reset_edge_valid", edge_str_valid, 0);
        check("reset_src_str", src_node_str, 0);
        check("reset_dst_str", dst_node_str, 0);
        check("reset_done", decoding_done_str, 0);
        check("reset_error", parse_error, 0);
        check("reset_lines", line_count, 0);
        check("reset_edges", edge_count, 0);
        rst = 1'b0;
        expQ.delete(); issueCyc.delete();
        doneRiseCyc = -1;
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < itemQ.size(); i++) begin
            if (randGaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                inbound_valid = 1'b0; end_of_input = 1'b0;
            end
            @(negedge clk);
            inbound_byte  = itemQ[i].b;
            inbound_valid = itemQ[i].hasByte;
            end_of_input  = itemQ[i].eoi;
            issueCyc.push_back(cycleCnt);
        end
        @(negedge clk);
        inbound_valid = 1'b0; end_of_input = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 50 && expQ.size() != 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        check("scoreboard_drained", expQ.size(), 0);
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_parse_error"}, parse_error, mErr);
        check({tag, "_line_count"}, line_count, mLines);
        check({tag, "_edge_count"}, edge_count, mEdges);
        check({tag, "_src_hold"}, src_node_str, mSrc);
        check({tag, "_dst_hold"}, dst_node_str, mDst);
        check({tag, "_done_level"}, decoding_done_str, 1);
        check({tag, "_done_cycle"}, doneRiseCyc,
              issueCyc[mEndIdx] + 1 + int'(mSim) + int'(mFlush));
    endtask

    task automatic runTest(input string tag);
        applyReset();
        runModel();
        applyStimulus();
        waitDrain();
        checkOutput(tag);
        itemQ.delete();
    endtask

    // Monitor: every pulse is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (src_node_str_valid || edge_str_valid) begin
                check("pulse_exclusive", src_node_str_valid && edge_str_valid, 0);
                if (expQ.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    monE = expQ.pop_front();
                    check("pulse_kind", edge_str_valid, monE.isEdge);
                    check("pulse_str", monE.isEdge ? dst_node_str : src_node_str, monE.str);
                    if (monE.refIdx < issueCyc.size())
                        check("pulse_cycle", cycleCnt, issueCyc[monE.refIdx] + 1 + monE.extra);
                    else
                        check("pulse_cycle", cycleCnt, -1);
                    check("pulse_lines", line_count, monE.lines);
                    check("pulse_edges", edge_count, monE.edges);
                end
            end
            if (decoding_done_str && doneRiseCyc < 0) doneRiseCyc = cycleCnt;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; inbound_byte = 8'h00; inbound_valid = 1'b0; end_of_input = 1'b0;

        addText("you: out\n"); addEnd();
        runTest("single_line");
        check("single_src_const", src_node_str, 15'h51D8);
        check("single_dst_const", dst_node_str, 15'h4E8E);

        addText("aaa: bbb ccc\nbbb: out\n"); addEnd();
        runTest("two_lines");
        check("two_lines_dst_const", dst_node_str, 15'h4E8E);
        repeat (5) @(negedge clk);
        check("done_sticky", decoding_done_str, 1);

        addText("you: ou"); addByte(8'h74, 1'b1);
        runTest("flush_no_lf");
        check("flush_error_const", parse_error, 0);

        addText("yoU: out\nabc: def\n"); addEnd();
        runTest("bad_line");
        check("bad_line_src_const", src_node_str, 15'h0820);
        check("bad_line_dst_const", dst_node_str, 15'h1483);

        addByte(8'h0D, 1'b0); addByte(8'h0A, 1'b0); addByte(8'h0A, 1'b0);
        addText("abc: def"); addByte(8'h0D, 1'b0); addByte(8'h0A, 1'b0); addEnd();
        runTest("blank_cr");

        applyReset();
        addText("abc: de");
        runModel();
        applyStimulus();
        waitDrain();
        itemQ.delete();
        addText("xyz: abc\n"); addEnd();
        runTest("after_reset");
        check("after_reset_src_const", src_node_str, 15'h6717);
        check("after_reset_dst_const", dst_node_str, 15'h0820);

        randGaps = 1'b1;
        for (int r = 0; r < 20; r++) begin
            addRandomText();
            runTest("random");
        end

        $display("%0d/%0d checks passed", checkPass, checkTotal);
        $finish;
    end

endmodule
